// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: blanking constants,
// scan state encoding and index-width helper.
package sseg_scan_ctrl_pkg;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;
    localparam logic [7:0] SSEG_OFF   = 8'hFF;
    // Anodes are active low; this is the value of one deselected anode bit.
    localparam logic       AN_OFF     = 1'b1;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [0:0] {
        StIdleBlank,
        StScan
    } scan_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Load channel between the BCD producer and the scan controller: a frame of digits
// and decimal points offered under a req/ack handshake.
interface sseg_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 4
);

    logic [4*N_DIGITS-1:0] bcd_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load_req;
    logic                  load_ack;

    modport master (
        output bcd_in,
        output dp_in,
        output load_req,
        input  load_ack
    );

    modport slave (
        input  bcd_in,
        input  dp_in,
        input  load_req,
        output load_ack
    );

endinterface

// File: rtl/dec_to_sseg.sv
// BCD to active-low seven-segment decoder; sseg[6:0] = a..g, sseg[7] = dp.
// Out-of-range codes 10..15 show the '9' pattern.
module dec_to_sseg (
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [6:0] seg;

    always_comb begin
        seg = 7'b0000100;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            default: seg = 7'b0000100;
        endcase
        sseg = {dp, seg};
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display. A shadow
// frame is swapped in only at frame end so a frame never mixes old and new digits.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    sseg_scan_ctrl_if.slave     load,
    input  logic                blank_lz,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          sseg,
    output logic                frame_tick
);

    localparam int unsigned IDX_W = idx_width(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    scan_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]   bcd_q;
    logic [N_DIGITS-1:0]        dp_q;
    logic [N_DIGITS-1:0]        an_q, an_d;
    logic [7:0]                 sseg_q, sseg_d;

    logic                       cnt_last;
    logic                       idx_last;
    logic                       frame_end;
    logic [N_DIGITS-1:0]        lz_mask;
    logic                       zero_run;
    logic [3:0]                 sel_bcd;
    logic                       sel_dp;
    logic [7:0]                 dec_sseg;

    assign cnt_last  = (cnt_q == CNT_LAST);
    assign idx_last  = (idx_q == IDX_LAST);
    assign frame_end = (state_q == StScan) && cnt_last && idx_last;

    // Reset wins over a frame end, so a pending request is dropped without an ack.
    assign frame_tick    = frame_end && !reset;
    assign load.load_ack = frame_tick && load.load_req;

    // A digit is blank when it and every digit to its left are zero; digit 0 never is.
    always_comb begin
        lz_mask  = '0;
        zero_run = blank_lz;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            zero_run   = zero_run && (bcd_q[i] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    assign sel_bcd = bcd_q[idx_q];
    assign sel_dp  = dp_q[idx_q];

    dec_to_sseg u_dec (
        .bcd  (sel_bcd),
        .dp   (sel_dp),
        .sseg (dec_sseg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        an_d    = {N_DIGITS{AN_OFF}};
        sseg_d  = SSEG_OFF;
        case (state_q)
            StIdleBlank: begin
                state_d = StScan;
            end
            StScan: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    idx_d = idx_last ? '0 : idx_q + 1'b1;
                end
                // First dwell cycle of each digit keeps all anodes off to avoid ghosting.
                if (cnt_q != '0) begin
                    an_d[idx_q] = 1'b0;
                end
                sseg_d = {dec_sseg[7], lz_mask[idx_q] ? SSEG_BLANK : dec_sseg[6:0]};
            end
            default: begin
                state_d = StIdleBlank;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdleBlank;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '1;
            an_q    <= '1;
            sseg_q  <= SSEG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            if (load.load_ack) begin
                bcd_q <= load.bcd_in;
                dp_q  <= load.dp_in;
            end
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with a 4-digit display and a 4-cycle dwell:
// table of frames with hand-decoded segments plus handshake and reset sequences.
module tb_sseg_scan_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 4;

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_an   = 0;

    vec_t vecs [7];
    vec_t v_rst;
    vec_t v9;

    sseg_scan_ctrl_if #(.N_DIGITS(ND)) lif ();

    sseg_scan_ctrl #(
        .N_DIGITS     (ND),
        .DWELL_CYCLES (DW),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (lif),
        .blank_lz   (blank_lz),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(~an) > 1) bad_an++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
    endtask

    // Checks one whole frame of outputs. With sync set, first waits for a frame_tick.
    task automatic check_frame(input vec_t v, input bit sync, input string tag);
        bit         found;
        logic [3:0] exp_an;
        int         d;
        int         c;
        blank_lz = v.lz;
        if (sync) begin
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (frame_tick) found = 1'b1;
            end
            check($sformatf("%s sync", tag), 16'(found), 16'd1);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = k / 4;
            c = k % 4;
            exp_an = (c == 0) ? 4'hF : ~(4'b0001 << d);
            check($sformatf("%s an k=%0d", tag, k), 16'(an), 16'(exp_an));
            check($sformatf("%s sseg k=%0d", tag, k), 16'(sseg), 16'(v.seg[d]));
            check($sformatf("%s tick k=%0d", tag, k), 16'(frame_tick), 16'(k == 14));
            check($sformatf("%s ack k=%0d", tag, k), 16'(lif.load_ack), 16'd0);
        end
    endtask

    task automatic do_load(input vec_t v, input string tag);
        bit got;
        lif.bcd_in   = v.bcd;
        lif.dp_in    = v.dp;
        lif.load_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (lif.load_ack) got = 1'b1;
        end
        check($sformatf("%s ack", tag), 16'(got), 16'd1);
        check($sformatf("%s tick@ack", tag), 16'(frame_tick), 16'd1);
        @(posedge clk);
        #1;
        lif.load_req = 1'b0;
        lif.bcd_in   = 16'hEEEE;
        lif.dp_in    = 4'h0;
    endtask

    // Asserts reset, checks the cleared outputs, the idle-blank cycle and the
    // restart at digit 0, then a full frame of the reset shadow.
    task automatic reset_and_check(input string tag);
        int cnt;
        bit found;
        reset = 1'b1;
        #1;
        check($sformatf("%s ack in reset", tag), 16'(lif.load_ack), 16'd0);
        @(negedge clk);
        check($sformatf("%s an", tag), 16'(an), 16'hF);
        check($sformatf("%s sseg", tag), 16'(sseg), 16'hFF);
        check($sformatf("%s ack", tag), 16'(lif.load_ack), 16'd0);
        check($sformatf("%s tick", tag), 16'(frame_tick), 16'd0);
        lif.load_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check($sformatf("%s idle an", tag), 16'(an), 16'hF);
        check($sformatf("%s idle sseg", tag), 16'(sseg), 16'hFF);
        @(negedge clk);
        check($sformatf("%s d0 dead an", tag), 16'(an), 16'hF);
        check($sformatf("%s d0 sseg", tag), 16'(sseg), 16'h81);
        @(negedge clk);
        check($sformatf("%s d0 an", tag), 16'(an), 16'hE);
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_tick) found = 1'b1;
        end
        check($sformatf("%s first tick delay", tag), 16'(cnt), 16'd13);
        check_frame(v_rst, 1'b0, {tag, " frame"});
    endtask

    initial begin
        int acks;
        lif.bcd_in   = 16'h0;
        lif.dp_in    = 4'hF;
        lif.load_req = 1'b0;

        v_rst   = '{16'h0000, 4'hF, 1'b0, {8'h81, 8'h81, 8'h81, 8'h81}};
        v9      = '{16'h9999, 4'h5, 1'b1, {8'h04, 8'h84, 8'h04, 8'h84}};
        vecs[0] = '{16'h1234, 4'hF, 1'b0, {8'hCF, 8'h92, 8'h86, 8'hCC}};
        vecs[1] = '{16'h0050, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hA4, 8'h81}};
        vecs[2] = '{16'h0000, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h81}};
        vecs[3] = '{16'h000C, 4'hE, 1'b0, {8'h81, 8'h81, 8'h81, 8'h04}};
        vecs[4] = '{16'h1008, 4'hF, 1'b1, {8'hCF, 8'h81, 8'h81, 8'h80}};
        vecs[5] = '{16'h00F7, 4'hB, 1'b1, {8'hFF, 8'h7F, 8'h84, 8'h8F}};
        vecs[6] = '{16'h0050, 4'hF, 1'b0, {8'h81, 8'h81, 8'hA4, 8'h81}};

        reset_and_check("rst");

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i], $sformatf("v%0d", i));
            check_frame(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // Request raised mid-frame: ack lands exactly on the frame end, old digits until then.
        repeat (5) @(negedge clk);
        lif.bcd_in   = v9.bcd;
        lif.dp_in    = v9.dp;
        lif.load_req = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            check($sformatf("mid sseg j=%0d", j), 16'(sseg), 16'(vecs[6].seg[(4 + j) / 4]));
            check($sformatf("mid ack j=%0d", j), 16'(lif.load_ack), 16'(j == 10));
            check($sformatf("mid tick j=%0d", j), 16'(frame_tick), 16'(j == 10));
        end
        @(posedge clk);
        #1;
        lif.load_req = 1'b0;
        check_frame(v9, 1'b0, "mid new");

        // Withdrawn request: nothing captured, no ack.
        lif.bcd_in   = 16'h8888;
        lif.dp_in    = 4'h0;
        lif.load_req = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (lif.load_ack) acks++;
        end
        lif.load_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lif.load_ack) acks++;
        end
        check("withdraw acks", 16'(acks), 16'd0);
        check_frame(v9, 1'b1, "withdraw");

        // Reset while digit 2 is on screen and a request is pending.
        lif.bcd_in   = 16'h5555;
        lif.dp_in    = 4'h0;
        lif.load_req = 1'b1;
        acks = 0;
        repeat (9) begin
            @(negedge clk);
            if (lif.load_ack) acks++;
        end
        check("pre-reset acks", 16'(acks), 16'd0);
        reset_and_check("midrst");

        check("an one-cold", 16'(bad_an), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
